spiker_out_collector: RTL and testbench
=======================================

// Module: spiker_out_collector
// PURPOSE
//   Collects the spiking core's output spike vector, delivered as a stream of WIDTH-bit words.
//   Packs the words into one DATA_WIDTH-bit frame.
//   Presents the frame on data_out_o with a one-cycle sample_o strobe to the hw2reg writer stage,
//   which captures it into the spikes_result registers.
//   Tracks aborted and timed-out frames for software.
// PARAMETERS
//   WIDTH        32    word width; equals one spikes_result register
//   DATA_WIDTH   768   frame width; DATA_WIDTH % WIDTH == 0 is required
//   N_WORDS      DATA_WIDTH/WIDTH (localparam, 24)   words per frame
//   TIMEOUT      1024  max idle cycles between words inside a frame; 0 disables the timeout
//   FRAME_CNT_W  16    width of the committed-frame counter
// PORTS
//   clk_i         in   1            clock
//   rst_i         in   1            synchronous reset, active-high
//   start_i       in   1            pulse: begin collecting a new frame
//   word_i        in   WIDTH        output spike word from core
//   word_valid_i  in   1            word_i valid
//   word_ready_o  out  1            collector accepts word_i
//   clear_err_i   in   1            pulse: clear err_o and timeout_o
//   data_out_o    out  DATA_WIDTH   last committed frame, to writer data_out_i
//   sample_o      out  1            one-cycle commit strobe, to writer sample_i
//   busy_o        out  1            state != IDLE
//   err_o         out  1            sticky: a frame was aborted by start_i
//   timeout_o     out  1            sticky: a frame was aborted by timeout
//   frame_cnt_o   out  FRAME_CNT_W  committed frames, wraps modulo 2^FRAME_CNT_W
// BEHAVIOUR
//   Reset (rst_i=1 at a posedge) forces the following:
//   - state=IDLE; word_cnt=0; timer=0; pending=0.
//   - All outputs 0, including data_out_o.
//   - Reset mid-frame discards the partial frame and produces no sample_o.
//   A handshake occurs when word_valid_i && word_ready_o at a posedge.
//   word_ready_o is a registered output: 1 only in COLLECT.
//   States:
//   - IDLE: start_i -> COLLECT, with word_cnt=0 and timer=0. Words are not accepted.
//   - COLLECT:
//     - On each handshake, the word is written to buf[(word_cnt+1)*WIDTH-1 -: WIDTH], word_cnt++, timer=0.
//     - Word j therefore lands in writer register j.
//     - When the handshake is on word_cnt==N_WORDS-1:
//       data_out_o <= buf with the last word merged in (same edge); frame_cnt_o++; -> COMMIT.
//     - A cycle with no handshake increments timer.
//     - If TIMEOUT!=0 and timer==TIMEOUT-1 with no handshake:
//       timeout_o <= 1; -> IDLE; the partial frame is discarded; data_out_o is unchanged.
//     - start_i in COLLECT restarts the frame (word_cnt=0, timer=0) and sets err_o.
//       start_i wins over a same-cycle handshake: that word is dropped.
//   - COMMIT: sample_o=1 for exactly this cycle; data_out_o is stable and valid.
//     - Next state is COLLECT if pending, otherwise IDLE. pending is cleared.
//     - start_i arriving in COMMIT sets pending, so the start is not lost.
//   Latency and stability:
//   - sample_o rises in the cycle after the last handshake edge.
//   - Minimum frame is N_WORDS+1 cycles from the first handshake to the end of sample_o.
//   - data_out_o changes only at the commit edge.
//     It stays constant across the sample_o cycle and holds until the next commit.
//   Sticky flags: clear_err_i clears err_o and timeout_o.
//   - A set event in the same cycle as clear_err_i wins: the flag ends at 1.
//   Counters:
//   - word_cnt is $clog2(N_WORDS) bits, never exceeds N_WORDS-1, and has no wrap inside a frame.
//   - timer is $clog2(TIMEOUT+1) bits and saturates.
//   - frame_cnt_o wraps from 2^FRAME_CNT_W-1 to 0.
//   Upstream may hold word_valid_i high continuously: one word is accepted per cycle in COLLECT.
// TESTING
//   1. start; 24 words 0x0000_0000..0x0000_0017 back-to-back ->
//      sample_o is one pulse one cycle after word 23; data_out_o[31:0]=0, [767:736]=0x17; frame_cnt_o=1.
//   2. Same frame with word_valid_i toggled randomly, gaps <100 cycles ->
//      identical data_out_o; exactly one sample_o; timeout_o=0.
//   3. start; 5 words, then valid held low for 1024 cycles ->
//      timeout_o=1; busy_o=0; no sample_o; data_out_o still holds the previous frame.
//   4. start; 10 words; start_i asserted together with word 10; then 24 words 0xA5A5_0000+j ->
//      err_o=1; frame holds only the new words; word 10 of the old frame is absent.
//   5. start_i pulsed during COMMIT ->
//      FSM returns to COLLECT; a second frame completes with a second sample_o; frame_cnt_o=2.
//   6. rst_i at word 12; then clear_err_i with a simultaneous restart abort ->
//      all outputs 0 after reset; err_o remains 1 (set wins over clear).

Source files
------------

// File: rtl/spiker_out_collector.sv
// Spike output collector: packs a stream of WIDTH-bit spike words into one
// DATA_WIDTH-bit frame and hands it to the hw2reg writer with a one-cycle strobe.
// Aborted (restart) and timed-out frames are flagged sticky for software.
module spiker_out_collector #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned DATA_WIDTH  = 768,
    parameter int unsigned TIMEOUT     = 1024,
    parameter int unsigned FRAME_CNT_W = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [WIDTH-1:0]       word_i,
    input  logic                   word_valid_i,
    output logic                   word_ready_o,
    input  logic                   clear_err_i,
    output logic [DATA_WIDTH-1:0]  data_out_o,
    output logic                   sample_o,
    output logic                   busy_o,
    output logic                   err_o,
    output logic                   timeout_o,
    output logic [FRAME_CNT_W-1:0] frame_cnt_o
);

    localparam int unsigned N_WORDS = DATA_WIDTH / WIDTH;
    localparam int unsigned CntW    = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int unsigned TimerW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [CntW-1:0]   LastCnt   = CntW'(N_WORDS - 1);
    localparam logic [TimerW-1:0] TimerLast = (TIMEOUT > 0) ? TimerW'(TIMEOUT - 1) : '0;
    localparam logic [TimerW-1:0] TimerMax  = '1;

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StCommit
    } state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        word_cnt_q, word_cnt_d;
    logic [TimerW-1:0]      timer_q, timer_d;
    logic [DATA_WIDTH-1:0]  frame_q, frame_d;
    logic [DATA_WIDTH-1:0]  data_out_q, data_out_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic                   word_ready_q, word_ready_d;
    logic                   err_q, err_d;
    logic                   timeout_q, timeout_d;
    logic                   err_set, timeout_set;
    logic                   handshake;

    assign handshake = word_valid_i && word_ready_q;

    // Next-state, frame assembly and commit decision.
    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        timer_d     = timer_q;
        frame_d     = frame_q;
        data_out_d  = data_out_q;
        frame_cnt_d = frame_cnt_q;
        err_set     = 1'b0;
        timeout_set = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d    = StCollect;
                    word_cnt_d = '0;
                    timer_d    = '0;
                end
            end
            StCollect: begin
                if (start_i) begin
                    // Restart wins over a same-cycle word; that word is dropped.
                    word_cnt_d = '0;
                    timer_d    = '0;
                    err_set    = 1'b1;
                end else if (handshake) begin
                    frame_d[word_cnt_q*WIDTH +: WIDTH] = word_i;
                    timer_d = '0;
                    if (word_cnt_q == LastCnt) begin
                        // Last word is merged into the published frame on this same edge.
                        data_out_d  = frame_d;
                        frame_cnt_d = frame_cnt_q + 1'b1;
                        word_cnt_d  = '0;
                        state_d     = StCommit;
                    end else begin
                        word_cnt_d = word_cnt_q + 1'b1;
                    end
                end else if ((TIMEOUT != 0) && (timer_q == TimerLast)) begin
                    timeout_set = 1'b1;
                    word_cnt_d  = '0;
                    timer_d     = '0;
                    state_d     = StIdle;
                end else if (timer_q != TimerMax) begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StCommit: begin
                // A start seen during the strobe cycle is folded straight into the exit
                // decision, so it is never lost and needs no storage beyond this cycle.
                state_d    = start_i ? StCollect : StIdle;
                word_cnt_d = '0;
                timer_d    = '0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Setting a sticky flag beats a simultaneous clear.
        err_d        = (err_q & ~clear_err_i) | err_set;
        timeout_d    = (timeout_q & ~clear_err_i) | timeout_set;
        word_ready_d = (state_d == StCollect);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            word_cnt_q   <= '0;
            timer_q      <= '0;
            frame_q      <= '0;
            data_out_q   <= '0;
            frame_cnt_q  <= '0;
            word_ready_q <= 1'b0;
            err_q        <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            timer_q      <= timer_d;
            frame_q      <= frame_d;
            data_out_q   <= data_out_d;
            frame_cnt_q  <= frame_cnt_d;
            word_ready_q <= word_ready_d;
            err_q        <= err_d;
            timeout_q    <= timeout_d;
        end
    end

    assign word_ready_o = word_ready_q;
    assign data_out_o   = data_out_q;
    assign sample_o     = (state_q == StCommit);
    assign busy_o       = (state_q != StIdle);
    assign err_o        = err_q;
    assign timeout_o    = timeout_q;
    assign frame_cnt_o  = frame_cnt_q;

endmodule

// File: tb/tb_spiker_out_collector.sv
// Scoreboard bench for spiker_out_collector: stimulus pushes expected frames,
// a negedge monitor pops and compares whenever sample_o is high.
module tb_spiker_out_collector;

    localparam int W  = 32;
    localparam int DW = 768;
    localparam int NW = DW / W;
    localparam int TO = 1024;
    localparam int FW = 16;

    logic           clk_i        = 1'b0;
    logic           rst_i        = 1'b1;
    logic           start_i      = 1'b0;
    logic [W-1:0]   word_i       = '0;
    logic           word_valid_i = 1'b0;
    logic           clear_err_i  = 1'b0;
    logic           word_ready_o;
    logic [DW-1:0]  data_out_o;
    logic           sample_o;
    logic           busy_o;
    logic           err_o;
    logic           timeout_o;
    logic [FW-1:0]  frame_cnt_o;

    spiker_out_collector #(
        .WIDTH      (W),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TO),
        .FRAME_CNT_W(FW)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .word_i      (word_i),
        .word_valid_i(word_valid_i),
        .word_ready_o(word_ready_o),
        .clear_err_i (clear_err_i),
        .data_out_o  (data_out_o),
        .sample_o    (sample_o),
        .busy_o      (busy_o),
        .err_o       (err_o),
        .timeout_o   (timeout_o),
        .frame_cnt_o (frame_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [DW-1:0] data;
        logic [FW-1:0] cnt;
    } frame_t;

    frame_t        sb_q[$];
    int            checks     = 0;
    int            fails      = 0;
    int            sample_cnt = 0;
    int            exp_cnt    = 0;
    logic [DW-1:0] last_frame = '0;

    // Monitor: every strobe must match the oldest expected frame.
    always @(negedge clk_i) begin
        frame_t e;
        if (!rst_i && sample_o) begin
            sample_cnt++;
            checks++;
            if (sb_q.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected_sample: got sample_o=1, required no strobe");
            end else begin
                e = sb_q.pop_front();
                if (data_out_o !== e.data) begin
                    fails++;
                    $display("FAIL sb_frame_data: got %h required %h", data_out_o, e.data);
                end
                checks++;
                if (frame_cnt_o !== e.cnt) begin
                    fails++;
                    $display("FAIL sb_frame_cnt: got %0d required %0d", frame_cnt_o, e.cnt);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!word_ready_o && n < 200) begin
            tick();
            n++;
        end
        if (!word_ready_o) begin
            checks++;
            fails++;
            $display("FAIL wait_ready: got word_ready_o=0 required 1 within 200 cycles");
        end
    endtask

    // Full frame with optional random idle gaps; expected result queued up front.
    task automatic send_frame(input logic [W-1:0] base, input int max_gap);
        logic [DW-1:0] exp_data;
        int            gap;
        for (int j = 0; j < NW; j++) exp_data[j*W +: W] = base + W'(j);
        exp_cnt++;
        sb_q.push_back('{exp_data, FW'(exp_cnt)});
        last_frame = exp_data;
        for (int j = 0; j < NW; j++) begin
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            if (gap > 0) begin
                word_valid_i = 1'b0;
                repeat (gap) tick();
            end
            word_i       = base + W'(j);
            word_valid_i = 1'b1;
            wait_ready();
            tick();
        end
        word_valid_i = 1'b0;
    endtask

    // Partial frame, back-to-back, never completes.
    task automatic send_partial(input logic [W-1:0] base, input int n);
        for (int j = 0; j < n; j++) begin
            word_i       = base + W'(j);
            word_valid_i = 1'b1;
            wait_ready();
            tick();
        end
        word_valid_i = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"},    64'(data_out_o == '0), 1);
        check({tag, "_sample"},  sample_o, 0);
        check({tag, "_busy"},    busy_o, 0);
        check({tag, "_ready"},   word_ready_o, 0);
        check({tag, "_err"},     err_o, 0);
        check({tag, "_timeout"}, timeout_o, 0);
        check({tag, "_fcnt"},    frame_cnt_o, 0);
    endtask

    initial begin
        int s0;

        // Reset state
        rst_i = 1'b1;
        repeat (3) tick();
        check_all_zero("reset");
        rst_i = 1'b0;
        tick();

        // T1: back-to-back frame, strobe one cycle after the last word
        pulse_start();
        check("t1_ready", word_ready_o, 1);
        check("t1_busy", busy_o, 1);
        s0 = sample_cnt;
        send_frame(32'h0000_0000, 0);
        check("t1_sample_now", sample_o, 1);
        check("t1_word0", data_out_o[31:0], 64'h0);
        check("t1_word23", data_out_o[767:736], 64'h17);
        check("t1_fcnt", frame_cnt_o, 1);
        check("t1_ready_commit", word_ready_o, 0);
        tick();
        check("t1_sample_gone", sample_o, 0);
        check("t1_idle", busy_o, 0);
        check("t1_sample_count", sample_cnt - s0, 1);

        // T2: same frame with random gaps
        pulse_start();
        s0 = sample_cnt;
        send_frame(32'h0000_0000, 5);
        repeat (2) tick();
        check("t2_sample_count", sample_cnt - s0, 1);
        check("t2_timeout", timeout_o, 0);
        check("t2_fcnt", frame_cnt_o, 2);

        // T3: stall after 5 words; timeout fires on the 1024th idle cycle
        pulse_start();
        s0 = sample_cnt;
        send_partial(32'h0BAD_0000, 5);
        repeat (TO - 1) tick();
        check("t3_busy_before", busy_o, 1);
        check("t3_timeout_before", timeout_o, 0);
        tick();
        check("t3_busy_after", busy_o, 0);
        check("t3_timeout_after", timeout_o, 1);
        check("t3_no_sample", sample_cnt - s0, 0);
        check("t3_data_held", 64'(data_out_o == last_frame), 1);
        check("t3_fcnt", frame_cnt_o, 2);
        clear_err_i = 1'b1;
        tick();
        clear_err_i = 1'b0;
        check("t3_timeout_clr", timeout_o, 0);

        // T4: restart collides with word 10; only the new words survive
        pulse_start();
        send_partial(32'hDEAD_0000, 10);
        word_i       = 32'hDEAD_000A;
        word_valid_i = 1'b1;
        start_i      = 1'b1;
        tick();
        start_i      = 1'b0;
        word_valid_i = 1'b0;
        check("t4_err", err_o, 1);
        check("t4_busy", busy_o, 1);
        s0 = sample_cnt;
        send_frame(32'hA5A5_0000, 0);
        tick();
        check("t4_sample_count", sample_cnt - s0, 1);
        check("t4_fcnt", frame_cnt_o, 3);

        // Fresh counters for T5
        rst_i = 1'b1;
        tick();
        rst_i   = 1'b0;
        exp_cnt = 0;
        check("rst2_fcnt", frame_cnt_o, 0);
        check("rst2_err", err_o, 0);

        // T5: start during COMMIT chains a second frame
        pulse_start();
        s0 = sample_cnt;
        send_frame(32'h1111_0000, 0);
        check("t5_in_commit", sample_o, 1);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("t5_busy", busy_o, 1);
        check("t5_ready", word_ready_o, 1);
        check("t5_sample_low", sample_o, 0);
        send_frame(32'h2222_0000, 0);
        tick();
        check("t5_fcnt", frame_cnt_o, 2);
        check("t5_sample_count", sample_cnt - s0, 2);
        check("t5_idle", busy_o, 0);

        // T6: reset at word 12, then set-beats-clear on err
        pulse_start();
        s0 = sample_cnt;
        send_partial(32'h3333_0000, 12);
        word_i       = 32'h3333_000C;
        word_valid_i = 1'b1;
        rst_i        = 1'b1;
        tick();
        rst_i        = 1'b0;
        word_valid_i = 1'b0;
        exp_cnt      = 0;
        check_all_zero("t6_reset");
        pulse_start();
        send_partial(32'h4444_0000, 3);
        start_i     = 1'b1;
        clear_err_i = 1'b1;
        tick();
        start_i     = 1'b0;
        clear_err_i = 1'b0;
        check("t6_err_set_wins", err_o, 1);
        clear_err_i = 1'b1;
        tick();
        clear_err_i = 1'b0;
        check("t6_err_cleared", err_o, 0);
        repeat (3) tick();
        check("t6_no_sample", sample_cnt - s0, 0);
        check("sb_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
